// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter that shares one multicycle ALU between
// the main datapath (req0) and the auxiliary unit (req1). Operands are held
// on the ALU for the op latency; the result is returned on a valid/ready
// response channel.
module alu_scheduler #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [2:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_result_extra,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [31:0] rsp_result_extra,
  output logic [3:0]  rsp_flags,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_id;
  logic [3:0]  r_cnt;
  logic        r_rsp_id;
  logic [31:0] r_rsp_result;
  logic [31:0] r_rsp_extra;
  logic [3:0]  r_rsp_flags;

  logic        w_grant;
  logic        w_accept;
  logic        w_capture;
  logic [2:0]  w_acc_op;
  logic [31:0] w_acc_a;
  logic [31:0] w_acc_b;
  logic [3:0]  w_acc_cnt;

  // Arbitration, handshake decode and next-state selection
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_capture   = 1'b0;
    // Only-valid requester wins; on a tie the one not served last wins.
    if (req0_valid && req1_valid) w_grant = ~r_last_grant;
    else                          w_grant = req1_valid;
    if (r_state == S_IDLE) begin
      req0_ready = req0_valid & ~w_grant;
      req1_ready = req1_valid & w_grant;
    end
    w_accept  = req0_ready | req1_ready;
    w_acc_op  = w_grant ? req1_op : req0_op;
    w_acc_a   = w_grant ? req1_a  : req0_a;
    w_acc_b   = w_grant ? req1_b  : req0_b;
    w_acc_cnt = w_acc_op[2] ? MUL_CNT_INIT : 4'd0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (r_cnt == 4'd0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch on accept and EXEC latency countdown
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_cnt        <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
      r_op         <= w_acc_op;
      r_a          <= w_acc_a;
      r_b          <= w_acc_b;
      r_id         <= w_grant;
      r_cnt        <= w_acc_cnt;
    end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Response capture at the end of the EXEC window; held until overwritten
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_extra  <= '0;
      r_rsp_flags  <= '0;
    end else if (w_capture) begin
      r_rsp_id     <= r_id;
      r_rsp_result <= alu_result;
      r_rsp_extra  <= alu_result_extra;
      r_rsp_flags  <= alu_flags;
    end
  end

  assign alu_control      = r_op;
  assign alu_a            = r_a;
  assign alu_b            = r_b;
  assign rsp_valid        = (r_state == S_RESP);
  assign rsp_id           = r_rsp_id;
  assign rsp_result       = r_rsp_result;
  assign rsp_result_extra = r_rsp_extra;
  assign rsp_flags        = r_rsp_flags;
  assign busy             = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: behavioural ALU, scoreboard of expected
// responses pushed on accept and popped on response handshake.
module tb_alu_scheduler;

  localparam int unsigned MUL_LAT = 3;

  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] e;
    logic [31:0] r;
  } alu_t;

  typedef struct {
    logic        id;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    alu_t        res;
    int unsigned exp_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, alu_control;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [31:0] alu_result, alu_result_extra, rsp_result, rsp_result_extra;
  logic [3:0]  alu_flags, rsp_flags;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  alu_t        w_alu;

  always #5 clk = ~clk;

  alu_scheduler #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_result_extra(alu_result_extra),
    .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_result_extra(rsp_result_extra),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  // Reference ALU, flags {N,Z,C,V}
  function automatic alu_t ref_alu(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    alu_t o;
    logic [32:0] s;
    logic [63:0] p;
    logic signed [63:0] sa, sbv;
    o = '0; s = '0; p = '0;
    sa = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    case (op)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b};
        o.r = s[31:0];
        o.f[1] = s[32];
        o.f[0] = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      3'b001: begin
        o.r = a - b;
        o.f[1] = (a >= b);
        o.f[0] = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      3'b010: o.r = a & b;
      3'b011: o.r = a | b;
      3'b110: begin p = sa * sbv; o.r = p[31:0]; o.e = p[63:32]; end
      3'b111: begin p = {32'b0, a} * {32'b0, b}; o.r = p[31:0]; o.e = p[63:32]; end
      default: begin p = {32'b0, a} * {32'b0, b}; o.r = p[31:0]; end
    endcase
    if (op[2] && op[1]) begin
      o.f[3] = o.e[31];
      o.f[2] = ({o.e, o.r} == 64'd0);
    end else begin
      o.f[3] = o.r[31];
      o.f[2] = (o.r == 32'd0);
    end
    return o;
  endfunction

  assign w_alu            = ref_alu(alu_control, alu_a, alu_b);
  assign alu_result       = w_alu.r;
  assign alu_result_extra = w_alu.e;
  assign alu_flags        = w_alu.f;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned r0_pulses = 0;
  exp_t        q_exp[$];
  logic        glog[$];
  int unsigned gcyc[$];
  logic        prev_valid = 1'b0;
  exp_t        m_e;
  exp_t        m_p;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard push on accept, pop on handshake, timing checks
  always @(negedge clk) begin
    if (!reset) begin
      q_exp.delete();
      prev_valid = 1'b0;
    end else begin
      check("one_ready", 64'(req0_ready & req1_ready), 64'(0));
      if (req0_ready) r0_pulses++;
      if (req0_ready || req1_ready) begin
        m_e.id  = req1_ready;
        m_e.op  = req1_ready ? req1_op : req0_op;
        m_e.a   = req1_ready ? req1_a  : req0_a;
        m_e.b   = req1_ready ? req1_b  : req0_b;
        m_e.res = ref_alu(m_e.op, m_e.a, m_e.b);
        m_e.exp_cyc = cyc + 1 + (m_e.op[2] ? MUL_LAT : 1);
        q_exp.push_back(m_e);
        glog.push_back(m_e.id);
        gcyc.push_back(cyc + 1);
      end
      if (busy && !rsp_valid && q_exp.size() > 0) begin
        check("alu_control", 64'(alu_control), 64'(q_exp[0].op));
        check("alu_a", 64'(alu_a), 64'(q_exp[0].a));
        check("alu_b", 64'(alu_b), 64'(q_exp[0].b));
      end
      if (rsp_valid && !prev_valid) begin
        check("rsp_has_op", 64'(q_exp.size() != 0), 64'(1));
        if (q_exp.size() != 0) check("rsp_latency", 64'(cyc), 64'(q_exp[0].exp_cyc));
      end
      if (rsp_valid && rsp_ready && q_exp.size() != 0) begin
        m_p = q_exp.pop_front();
        check("sb_id", 64'(rsp_id), 64'(m_p.id));
        check("sb_result", 64'(rsp_result), 64'(m_p.res.r));
        check("sb_extra", 64'(rsp_result_extra), 64'(m_p.res.e));
        check("sb_flags", 64'(rsp_flags), 64'(m_p.res.f));
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic n, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    logic got;
    got = 1'b0;
    if (!n) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else    begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (n ? req1_ready : req0_ready) got = 1'b1;
    end
    check("accept_wait", 64'(got), 64'(1));
    tick();
    if (!n) req0_valid = 1'b0;
    else    req1_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    check("rsp_wait", 64'(got), 64'(1));
  endtask

  task automatic wait_idle();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (!busy && q_exp.size() == 0) got = 1'b1;
    end
    check("idle_wait", 64'(got), 64'(1));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       n;
    logic [2:0] op;
    int unsigned stall;
    logic [31:0] ra, rb;
    reset = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_result", 64'(rsp_result), 64'(0));
    check("rst_rsp_extra", 64'(rsp_result_extra), 64'(0));
    check("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    check("rst_alu_a", 64'(alu_a), 64'(0));
    tick();
    reset = 1'b1;
    tick();

    // req0 ADD
    rsp_ready = 1'b1;
    r0_pulses = 0;
    send(1'b0, 3'b000, 32'd5, 32'd7);
    wait_rsp();
    check("add_result", 64'(rsp_result), 64'd12);
    check("add_extra", 64'(rsp_result_extra), 64'd0);
    check("add_flags", 64'(rsp_flags), 64'b0000);
    check("add_id", 64'(rsp_id), 64'd0);
    wait_idle();
    check("r0_pulses", 64'(r0_pulses), 64'd1);

    // req1 SUB equal operands
    send(1'b1, 3'b001, 32'd3, 32'd3);
    wait_rsp();
    check("sub_result", 64'(rsp_result), 64'd0);
    check("sub_flags", 64'(rsp_flags), 64'b0110);
    check("sub_id", 64'(rsp_id), 64'd1);
    wait_idle();

    // Both requesters continuously valid: alternating grants, L+2 spacing
    glog.delete(); gcyc.delete();
    req0_op = 3'b000; req0_a = 32'd1;  req0_b = 32'd2;
    req1_op = 3'b000; req1_a = 32'd10; req1_b = 32'd20;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (glog.size() >= 4) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_count", 64'(glog.size()), 64'd4);
    if (glog.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", 64'(glog[i]), 64'(i % 2));
      for (int i = 0; i < 3; i++) check("rr_gap", 64'(gcyc[i+1] - gcyc[i]), 64'd3);
    end
    wait_idle();

    // SMULL, long latency
    send(1'b0, 3'b110, 32'hFFFF_FFFE, 32'd3);
    wait_rsp();
    check("smull_result", 64'(rsp_result), 64'hFFFF_FFFA);
    check("smull_extra", 64'(rsp_result_extra), 64'hFFFF_FFFF);
    check("smull_flags", 64'(rsp_flags), 64'b1000);
    check("smull_id", 64'(rsp_id), 64'd0);
    wait_idle();

    // Back-pressure on the response with req1 waiting
    rsp_ready = 1'b0;
    send(1'b0, 3'b000, 32'd100, 32'd23);
    wait_rsp();
    tick();
    req1_op = 3'b011; req1_a = 32'hF0; req1_b = 32'h0F; req1_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_result", 64'(rsp_result), 64'd123);
      check("hold_id", 64'(rsp_id), 64'd0);
      check("hold_r1_ready", 64'(req1_ready), 64'd0);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rsp_r1_ready", 64'(req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during UMULL EXEC
    send(1'b0, 3'b111, 32'd7, 32'd9);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rst_exec_busy", 64'(busy), 64'd0);
    check("rst_exec_valid", 64'(rsp_valid), 64'd0);
    check("rst_exec_result", 64'(rsp_result), 64'd0);
    check("rst_exec_flags", 64'(rsp_flags), 64'd0);
    repeat (8) begin
      @(negedge clk);
      check("rst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    tick();
    req0_op = 3'b000; req0_a = 32'd4; req0_b = 32'd4;
    req1_op = 3'b000; req1_a = 32'd6; req1_b = 32'd6;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("rst_tie_r0", 64'(req0_ready), 64'd1);
    check("rst_tie_r1", 64'(req1_ready), 64'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Randomised ops with random response stalls
    for (int k = 0; k < 16; k++) begin
      n = 1'($urandom_range(0, 1));
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      stall = $urandom_range(0, 3);
      rsp_ready = 1'b0;
      send(n, op, ra, rb);
      wait_rsp();
      tick();
      repeat (stall) tick();
      rsp_ready = 1'b1;
      wait_idle();
    end
    rsp_ready = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
